rr_ctz_scheduler: RTL and testbench

RR_CTZ_SCHEDULER -- requirements
Module: rr_ctz_scheduler

---
 rtl/rr_ctz_pkg.sv | 14 +
 rtl/ctz_find.sv | 19 +
 rtl/rr_ctz_scheduler.sv | 101 ++++++++++
 tb/tb_rr_ctz_scheduler.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/rr_ctz_pkg.sv
// rtl/rr_ctz_pkg.sv - shared FSM state type and index-width helper for the round-robin scheduler
package rr_ctz_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  // Width of an index into an n-entry bitmap (never narrower than one bit).
  function automatic int idx_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ctz_find.sv
// rtl/ctz_find.sv - combinational count-trailing-zeros; all-zero input yields DATA_WIDTH
module ctz_find #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0]         din,
  output logic [$clog2(DATA_WIDTH+1)-1:0] count
);

  localparam int CW = $clog2(DATA_WIDTH + 1);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    count = CW'(DATA_WIDTH);
    for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
      if (din[i]) count = CW'(i);
    end
  end

endmodule

// File: rtl/rr_ctz_scheduler.sv
// rtl/rr_ctz_scheduler.sv - round-robin event scheduler over a pending bitmap with registered offer/handshake output
module rr_ctz_scheduler
  import rr_ctz_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               set_vld,
  input  logic [DATA_WIDTH-1:0]              set_mask,
  input  logic                               flush,
  output logic                               dout_vld,
  input  logic                               dout_rdy,
  output logic [idx_width(DATA_WIDTH)-1:0]   dout_idx,
  output logic [DATA_WIDTH-1:0]              pending
);

  localparam int IW = idx_width(DATA_WIDTH);
  localparam int CW = $clog2(DATA_WIDTH + 1);

  state_t                state, state_n;
  logic [DATA_WIDTH-1:0] pend, pend_n, clr;
  logic [DATA_WIDTH-1:0] onehot, sel_x, thermo, masked;
  logic [IW-1:0]         ptr, ptr_n, idx, idx_n, wrap_idx, sel_p, sel_idx;
  logic [CW-1:0]         ctz_masked, ctz_full;
  logic                  hs;

  assign dout_vld = (state == OFFER);
  assign dout_idx = idx;
  assign pending  = pend;
  assign hs       = dout_vld & dout_rdy;

  assign onehot   = DATA_WIDTH'(1) << idx;
  assign wrap_idx = (int'(idx) == DATA_WIDTH - 1) ? '0 : idx + IW'(1);

  // One selector serves both cases: IDLE searches P from ptr, OFFER searches
  // the post-grant remainder from the slot after the granted index.
  assign sel_x  = (state == OFFER) ? (pend & ~onehot) : pend;
  assign sel_p  = (state == OFFER) ? wrap_idx : ptr;
  assign thermo = ~((DATA_WIDTH'(1) << sel_p) - DATA_WIDTH'(1));
  assign masked = sel_x & thermo;

  ctz_find #(.DATA_WIDTH(DATA_WIDTH)) u_ctz_masked (
    .din   (masked),
    .count (ctz_masked)
  );

  ctz_find #(.DATA_WIDTH(DATA_WIDTH)) u_ctz_full (
    .din   (sel_x),
    .count (ctz_full)
  );

  assign sel_idx = IW'((|masked) ? ctz_masked : ctz_full);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pend  <= '0;
      ptr   <= '0;
      idx   <= '0;
    end else begin
      state <= state_n;
      pend  <= pend_n;
      ptr   <= ptr_n;
      idx   <= idx_n;
    end
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    idx_n   = idx;
    clr     = '0;
    case (state)
      IDLE: begin
        if (pend != '0) begin
          idx_n   = sel_idx;
          state_n = OFFER;
        end
      end
      OFFER: begin
        if (hs) begin
          clr   = onehot;
          ptr_n = wrap_idx;
          if (sel_x != '0) idx_n = sel_idx;
          else             state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    // Set is OR-ed after the clear so a re-raised bit survives its own grant.
    pend_n = (pend & ~clr) | (set_vld ? set_mask : '0);
    if (flush) begin
      state_n = IDLE;
      ptr_n   = ptr;
      idx_n   = idx;
      pend_n  = '0;
    end
  end

endmodule

// File: tb/tb_rr_ctz_scheduler.sv
// tb/tb_rr_ctz_scheduler.sv - scoreboard bench for rr_ctz_scheduler against a round-robin reference model
module tb_rr_ctz_scheduler;

  localparam int N  = 8;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          set_vld = 1'b0;
  logic [N-1:0]  set_mask = '0;
  logic          flush = 1'b0;
  logic          dout_vld;
  logic          dout_rdy = 1'b0;
  logic [IW-1:0] dout_idx;
  logic [N-1:0]  pending;

  always #5 clk = ~clk;

  rr_ctz_scheduler #(.DATA_WIDTH(N)) dut (
    .clk      (clk),
    .reset    (reset),
    .set_vld  (set_vld),
    .set_mask (set_mask),
    .flush    (flush),
    .dout_vld (dout_vld),
    .dout_rdy (dout_rdy),
    .dout_idx (dout_idx),
    .pending  (pending)
  );

  typedef struct {
    logic          vld;
    logic          chk_idx;
    logic [IW-1:0] idx;
    logic [N-1:0]  p;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  logic [N-1:0] m_p   = '0;
  int           m_ptr = 0;
  logic         m_vld = 1'b0;
  int           m_idx = 0;

  // First set bit found walking upward from start, wrapping around.
  function automatic int rr_pick(input logic [N-1:0] bits, input int start);
    for (int k = 0; k < N; k++) begin
      if (bits[(start + k) % N]) return (start + k) % N;
    end
    return 0;
  endfunction

  task automatic cyc(input logic r, input logic f, input logic sv,
                     input logic [N-1:0] sm, input logic rdy);
    exp_t         e;
    logic [N-1:0] rem;
    @(negedge clk);
    reset    = r;
    flush    = f;
    set_vld  = sv;
    set_mask = sm;
    dout_rdy = rdy;
    e.chk_idx = 1'b0;
    if (r) begin
      m_p = '0; m_ptr = 0; m_vld = 1'b0; m_idx = 0;
      e.chk_idx = 1'b1;
    end else if (f) begin
      m_p = '0; m_vld = 1'b0;
    end else begin
      if (m_vld && rdy) begin
        rem      = m_p;
        rem[m_idx] = 1'b0;
        m_ptr    = (m_idx + 1) % N;
        if (rem != '0) m_idx = rr_pick(rem, m_ptr);
        else           m_vld = 1'b0;
        m_p = rem;
      end else if (!m_vld && m_p != '0) begin
        m_idx = rr_pick(m_p, m_ptr);
        m_vld = 1'b1;
      end
      if (sv) m_p = m_p | sm;
    end
    e.vld = m_vld;
    e.idx = IW'(m_idx);
    e.p   = m_p;
    if (m_vld) e.chk_idx = 1'b1;
    exp_q.push_back(e);
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      checks++;
      if (dout_vld !== mon_e.vld) begin
        errors++;
        $display("FAIL dout_vld at %0t: got %b expected %b", $time, dout_vld, mon_e.vld);
      end
      checks++;
      if (pending !== mon_e.p) begin
        errors++;
        $display("FAIL pending at %0t: got %h expected %h", $time, pending, mon_e.p);
      end
      if (mon_e.chk_idx) begin
        checks++;
        if (dout_idx !== mon_e.idx) begin
          errors++;
          $display("FAIL dout_idx at %0t: got %0d expected %0d", $time, dout_idx, mon_e.idx);
        end
      end
    end
  end

  initial begin
    cyc(1, 0, 0, 8'h00, 0);
    cyc(1, 0, 0, 8'h00, 0);
    // empty set does nothing
    cyc(0, 0, 1, 8'h00, 1);
    repeat (3) cyc(0, 0, 0, 8'h00, 1);
    // 0x28: grants 3 then 5, then idle
    cyc(0, 0, 1, 8'h28, 1);
    repeat (4) cyc(0, 0, 0, 8'h00, 1);
    // ptr=6, 0x41: grants 6 then wraps to 0
    cyc(0, 0, 1, 8'h41, 1);
    repeat (4) cyc(0, 0, 0, 8'h00, 1);
    // stall on idx 4, raise bit 0 meanwhile
    cyc(0, 0, 1, 8'h10, 0);
    cyc(0, 0, 0, 8'h00, 0);
    cyc(0, 0, 1, 8'h01, 0);
    repeat (2) cyc(0, 0, 0, 8'h00, 0);
    repeat (4) cyc(0, 0, 0, 8'h00, 1);
    // re-raise bit 2 during its own grant
    cyc(0, 0, 1, 8'h0C, 0);
    cyc(0, 0, 0, 8'h00, 0);
    cyc(0, 0, 1, 8'h04, 1);
    repeat (4) cyc(0, 0, 0, 8'h00, 1);
    // flush mid-offer, then grant order exposes ptr
    cyc(0, 0, 1, 8'hFF, 0);
    repeat (2) cyc(0, 0, 0, 8'h00, 0);
    cyc(0, 1, 1, 8'hFF, 1);
    cyc(0, 0, 0, 8'h00, 1);
    cyc(0, 0, 1, 8'h0F, 1);
    repeat (6) cyc(0, 0, 0, 8'h00, 1);
    // reset mid-offer, ptr returns to 0
    cyc(0, 0, 1, 8'hFF, 0);
    repeat (2) cyc(0, 0, 0, 8'h00, 0);
    cyc(1, 0, 1, 8'hFF, 1);
    cyc(0, 0, 1, 8'h0F, 1);
    repeat (6) cyc(0, 0, 0, 8'h00, 1);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 39) == 0),
          ($urandom_range(0, 1) == 1), N'($urandom), ($urandom_range(0, 9) < 7));
    end
    repeat (N + 2) cyc(0, 0, 0, 8'h00, 1);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
